// File: rtl/seq_mult.sv
// ---------------------------------------------------------------------------
// seq_mult -- sequential shift-add multiplier for the ALU datapath.
//
// Takes two size-bit operands on a start strobe and retires one partial
// product per clock. After size iterations it loads a registered 2*size-bit
// product and pulses done for one cycle. The product is held until the next
// completion, so a downstream pipeline register may sample p on any cycle and
// treat done as its "new data" qualifier.
//
// Ports
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        multiply request, sampled only while idle
//   a      in   size     multiplicand, sampled with start
//   b      in   size     multiplier, sampled with start
//   busy   out  1        high while a multiply is in progress
//   done   out  1        one-cycle pulse, p carries a new result
//   p      out  2*size   registered product, held between completions
//
// Configuration macro
//   SEQ_MULT_SIGNED_EN  when defined, a/b/p are two's complement. Operand
//                       magnitudes are multiplied and the result is negated
//                       when the operand signs differ. Latency is unchanged.
//                       When undefined, the block is unsigned only.
// ---------------------------------------------------------------------------
module seq_mult #(
  parameter int size = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [size-1:0]     a,
  input  logic [size-1:0]     b,
  output logic                busy,
  output logic                done,
  output logic [2*size-1:0]   p
);

  // The counter only has to reach size-1. The extra headroom keeps the
  // compare simple for any legal size.
  localparam int CW = $clog2(size + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t              state_q;
  logic [size-1:0]     mcand_q;
  logic [size-1:0]     mplier_q;
  // One bit wider than the product to hold the carry of each partial add.
  // The shift always brings a 0 into the top bit.
  logic [2*size:0]     acc_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [2*size-1:0]   p_q;
`ifdef SEQ_MULT_SIGNED_EN
  logic                sign_q;
`endif

  logic [size-1:0]     opA_d;
  logic [size-1:0]     opB_d;
  logic [size:0]       upperSum;
  logic [2*size:0]     accAdd;
  logic [2*size:0]     acc_d;
  logic                lastIter;
  logic [2*size-1:0]   result_d;

  // Operand capture values. In signed mode the magnitudes are latched. The
  // most-negative value maps to 2^(size-1), which still fits in size
  // unsigned bits, so the most-negative case stays exact.
  always_comb begin
    opA_d = a;
    opB_d = b;
`ifdef SEQ_MULT_SIGNED_EN
    if (a[size-1]) begin
      opA_d = ~a + size'(1);
    end
    if (b[size-1]) begin
      opB_d = ~b + size'(1);
    end
`endif
  end

  // One shift-add step. Add the multiplicand into the upper size+1 bits when
  // the current multiplier LSB is set, then shift the whole accumulator
  // right. After size steps the low 2*size bits hold the full product.
  always_comb begin
    upperSum = acc_q[2*size:size] + {1'b0, mcand_q};
    accAdd   = acc_q;
    if (mplier_q[0]) begin
      accAdd = {upperSum, acc_q[size-1:0]};
    end
    acc_d    = {1'b0, accAdd[2*size:1]};
    lastIter = (cnt_q == CW'(size - 1));
    result_d = acc_d[2*size-1:0];
`ifdef SEQ_MULT_SIGNED_EN
    if (sign_q) begin
      result_d = ~acc_d[2*size-1:0] + (2*size)'(1);
    end
`endif
  end

  // Control FSM and datapath registers. All outputs are registered.
  // done_q defaults low every edge, so it is a single-cycle pulse unless the
  // edge completes another multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= opA_d;
            mplier_q <= opB_d;
            acc_q    <= '0;
            cnt_q    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q   <= a[size-1] ^ b[size-1];
`endif
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (lastIter) begin
            p_q     <= result_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult. Products are predicted with plain integer
// arithmetic on the operands. The signed interpretation is used when
// SEQ_MULT_SIGNED_EN is defined.
module tb_seq_mult;

   localparam int SZ = 4;
   localparam int PW = 2 * SZ;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [SZ-1:0] a;
   logic [SZ-1:0] b;
   logic          busy;
   logic          done;
   logic [PW-1:0] p;

   int            checks = 0;
   int            errors = 0;
   logic [PW-1:0] lastP;

   seq_mult #(.size(SZ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   // Free-running clock; all sampling happens on the falling edge.
   always #5 clk = ~clk;

   // Reference product computed arithmetically, truncated to the product width.
   function automatic logic [PW-1:0] refProduct(input logic [SZ-1:0] x, input logic [SZ-1:0] y);
      longint sx;
      longint sy;
`ifdef SEQ_MULT_SIGNED_EN
      sx = longint'($signed(x));
      sy = longint'($signed(y));
`else
      sx = longint'(x);
      sy = longint'(y);
`endif
      return PW'(sx * sy);
   endfunction

   // Single comparison point; counts and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge while the DUT is idle or in its done cycle.
   // Issues one multiply, checks every busy cycle and then the done cycle.
   // disturbAt >= 0 raises start with new operands in that busy cycle.
   task automatic applyStimulus(input logic [SZ-1:0] x, input logic [SZ-1:0] y, input int disturbAt);
      logic [PW-1:0] expP;
      expP  = refProduct(x, y);
      start = 1'b1;
      a     = x;
      b     = y;
      for (int i = 0; i < SZ; i++) begin
         @(negedge clk);
         checkOutput("busyHigh", 32'(busy), 32'd1);
         checkOutput("doneLowInRun", 32'(done), 32'd0);
         checkOutput("pHeldInRun", 32'(p), 32'(lastP));
         if (i == 0) begin
            start = 1'b0;
            a     = SZ'($urandom);
            b     = SZ'($urandom);
         end
         if (i == disturbAt) begin
            start = 1'b1;
            a     = SZ'(2);
            b     = SZ'(2);
         end else if (i == disturbAt + 1) begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      checkOutput("donePulse", 32'(done), 32'd1);
      checkOutput("busyLowAtDone", 32'(busy), 32'd0);
      checkOutput("product", 32'(p), 32'(expP));
      lastP = expP;
      start = 1'b0;
   endtask

   // Idle cycles: nothing in flight, product held.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput("busyIdle", 32'(busy), 32'd0);
         checkOutput("doneIdle", 32'(done), 32'd0);
         checkOutput("pHeldIdle", 32'(p), 32'(lastP));
      end
   endtask

   initial begin
      logic [SZ-1:0] rx;
      logic [SZ-1:0] ry;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      lastP = '0;
      #12;
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
      checkOutput("resetP", 32'(p), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idleCycles(2);

      $display("[TB] 15 x 15 with product hold");
      applyStimulus(SZ'(15), SZ'(15), -1);
      idleCycles(3);

      $display("[TB] zero and identity");
      applyStimulus(SZ'(0), SZ'(9), -1);
      idleCycles(1);
      applyStimulus(SZ'(7), SZ'(1), -1);
      idleCycles(1);

      $display("[TB] back-to-back 3x5 then 6x6");
      applyStimulus(SZ'(3), SZ'(5), -1);
      applyStimulus(SZ'(6), SZ'(6), -1);
      idleCycles(2);

      $display("[TB] start and operand changes during run");
      applyStimulus(SZ'(10), SZ'(3), 1);
      idleCycles(3);

      $display("[TB] reset mid-operation");
      start = 1'b1;
      a     = SZ'(12);
      b     = SZ'(12);
      @(negedge clk);
      start = 1'b0;
      checkOutput("abortBusy1", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("abortBusy2", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("abortBusy3", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncBusy", 32'(busy), 32'd0);
      checkOutput("asyncDone", 32'(done), 32'd0);
      checkOutput("asyncP", 32'(p), 32'd0);
      lastP = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("noDoneInReset", 32'(done), 32'd0);
      end
      // Release and request in the same cycle: the release edge accepts start.
      rst_n = 1'b1;
      applyStimulus(SZ'(2), SZ'(3), -1);
      idleCycles(2);

      $display("[TB] sign handling");
      applyStimulus(SZ'(4'hF), SZ'(4'h1), -1);
`ifdef SEQ_MULT_SIGNED_EN
      checkOutput("minusOne", 32'(p), 32'h0000_00FF);
`else
      checkOutput("fifteen", 32'(p), 32'h0000_000F);
`endif
      idleCycles(1);
      applyStimulus(SZ'(4'h8), SZ'(4'h8), -1);
      checkOutput("eightByEight", 32'(p), 32'h0000_0040);
      idleCycles(1);

      $display("[TB] random operands");
      for (int n = 0; n < 24; n++) begin
         rx = SZ'($urandom);
         ry = SZ'($urandom);
         applyStimulus(rx, ry, -1);
         if ($urandom_range(0, 1) == 1) begin
            idleCycles(int'($urandom_range(1, 3)));
         end
      end
      idleCycles(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
